// File: rtl/rs_latch_driver.sv
// Command-side driver for an RS latch: turns accepted set/clear requests into
// non-overlapping, width-controlled s_out/r_out pulses with a minimum idle gap.
// Optional readback check of the latch output is enabled by RS_DRV_READBACK_EN.
module rs_latch_driver #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_set,
  output logic       cmd_ready,
  output logic       s_out,
  output logic       r_out,
  output logic       busy,
  output logic [7:0] pulse_cnt,
  input  logic       latch_q,
  output logic       err,
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam bit               HAS_GAP    = (GAP_W > 0);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = HAS_GAP ? CNT_W'(GAP_W - 1) : '0;

  state_t           state_p0;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       pulse_cnt_p0;
  logic             dir_p0;
  logic             dir_nxt;
  logic             s_p0;
  logic             r_p0;
  logic             s_nxt;
  logic             r_nxt;
  logic             last_cyc;
  logic             done_cyc;
  logic             accept;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // The final cycle of a pulse/gap window already accepts the next command,
  // which makes the minimum command period exactly PULSE_W+GAP_W cycles.
  assign last_cyc  = (cnt_p0 == '0);
  assign done_cyc  = ((state_p0 == GAP) && last_cyc) ||
                     ((state_p0 == PULSE) && last_cyc && !HAS_GAP);
  assign cmd_ready = (state_p0 == IDLE) || done_cyc;
  assign accept    = cmd_valid && cmd_ready;

  // ---- stage p0: control state ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0     <= IDLE;
      cnt_p0       <= '0;
      pulse_cnt_p0 <= '0;
      s_p0         <= 1'b0;
      r_p0         <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      s_p0     <= s_nxt;
      r_p0     <= r_nxt;
      if (accept)
        pulse_cnt_p0 <= pulse_cnt_p0 + 8'd1;
    end
  end

  // Direction is data: captured on accept, never needs a reset value.
  always_ff @(posedge clk) begin
    if (accept)
      dir_p0 <= cmd_set;
  end

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    if (accept) begin
      state_nxt = PULSE;
      cnt_nxt   = PULSE_LOAD;
    end else begin
      case (state_p0)
        PULSE: begin
          if (last_cyc) begin
            if (HAS_GAP) begin
              state_nxt = GAP;
              cnt_nxt   = GAP_LOAD;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = sat_dec(cnt_p0);
          end
        end
        GAP: begin
          if (last_cyc)
            state_nxt = IDLE;
          else
            cnt_nxt = sat_dec(cnt_p0);
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so S and R switch on the same
  // edge and can never be high together.
  always_comb begin
    busy    = (state_p0 != IDLE);
    dir_nxt = accept ? cmd_set : dir_p0;
    s_nxt   = (state_nxt == PULSE) && dir_nxt;
    r_nxt   = (state_nxt == PULSE) && !dir_nxt;
  end

  assign s_out     = s_p0;
  assign r_out     = r_p0;
  assign pulse_cnt = pulse_cnt_p0;

`ifdef RS_DRV_READBACK_EN
  logic err_p0;
  logic mismatch;

  // Latch output is compared on the cycle the driver hands back to IDLE.
  assign mismatch = done_cyc && (latch_q != dir_p0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_p0 <= 1'b0;
    else if (mismatch)
      err_p0 <= 1'b1;
    else if (err_clr)
      err_p0 <= 1'b0;
  end

  assign err = err_p0;
`else
  logic unused_readback;
  assign unused_readback = latch_q ^ err_clr;
  assign err             = 1'b0;
`endif

endmodule
